// File: rtl/sram_pkg.sv
// Shared constants and types for the SKY130 1rw1r 32x512 based memory array.
package sram_pkg;

    localparam int MACRO_ADDRESS_SIZE = 9;
    localparam int MACRO_WORD_SIZE    = 32;
    localparam int MACRO_DEPTH        = 512;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/sram_bank_row.sv
// One row of COLUMN_COUNT 1rw1r 32x512 macros sharing address and chip select,
// modelled behaviourally: inputs sampled on the clock edge, read data one edge later.
module sram_bank_row
    import sram_pkg::*;
#(
    parameter int COLUMN_COUNT = 1
) (
`ifdef USE_POWER_PINS
    inout  wire                                      vccd1,
    inout  wire                                      vssd1,
`endif
    input  logic                                     clk,
    input  logic                                     i_csb0,
    input  logic                                     i_web0,
    input  logic [4*COLUMN_COUNT-1:0]                i_wmask0,
    input  logic [MACRO_ADDRESS_SIZE-1:0]            i_addr0,
    input  logic [MACRO_WORD_SIZE*COLUMN_COUNT-1:0]  i_din0,
    output logic [MACRO_WORD_SIZE*COLUMN_COUNT-1:0]  o_dout0,
    input  logic                                     i_csb1,
    input  logic [MACRO_ADDRESS_SIZE-1:0]            i_addr1,
    output logic [MACRO_WORD_SIZE*COLUMN_COUNT-1:0]  o_dout1
);

    for (genvar c = 0; c < COLUMN_COUNT; c++) begin : g_column
        logic [MACRO_WORD_SIZE-1:0]    r_mem [MACRO_DEPTH];
        logic [MACRO_ADDRESS_SIZE-1:0] r_addr0;
        logic [MACRO_ADDRESS_SIZE-1:0] r_addr1;
        logic                          r_read0;
        logic                          r_read1;
        logic [MACRO_WORD_SIZE-1:0]    r_dout0;
        logic [MACRO_WORD_SIZE-1:0]    r_dout1;

        // Write mask bits [4c+3:4c] belong to this column.
        always_ff @(posedge clk) begin
            if (!i_csb0 && !i_web0) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_wmask0[4*c+b]) begin
                        r_mem[i_addr0][8*b +: 8] <= i_din0[MACRO_WORD_SIZE*c + 8*b +: 8];
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            r_read0 <= !i_csb0 && i_web0;
            r_read1 <= !i_csb1;
            r_addr0 <= i_addr0;
            r_addr1 <= i_addr1;
            if (r_read0) begin
                r_dout0 <= r_mem[r_addr0];
            end
            if (r_read1) begin
                r_dout1 <= r_mem[r_addr1];
            end
        end

        assign o_dout0[MACRO_WORD_SIZE*c +: MACRO_WORD_SIZE] = r_dout0;
        assign o_dout1[MACRO_WORD_SIZE*c +: MACRO_WORD_SIZE] = r_dout1;
    end

endmodule

// File: rtl/sram_bank_array.sv
// Multi-bank core-local memory: one read/write and one read-only port with
// handshakes, 2-cycle registered reads, write/read collision stall and clear-on-reset.
module sram_bank_array
    import sram_pkg::*;
#(
    parameter int BYTE_COUNT     = 4,
    parameter int ADDRESS_SIZE   = 9,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
`ifdef USE_POWER_PINS
    inout  wire                       vccd1,
    inout  wire                       vssd1,
`endif
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      primarySelect,
    input  logic                      primaryWriteEnable,
    input  logic [BYTE_COUNT-1:0]     primaryWriteMask,
    input  logic [ADDRESS_SIZE-1:0]   primaryAddress,
    input  logic [8*BYTE_COUNT-1:0]   primaryDataWrite,
    output logic                      primaryReady,
    output logic [8*BYTE_COUNT-1:0]   primaryDataRead,
    output logic                      primaryReadValid,
    input  logic                      secondarySelect,
    input  logic [ADDRESS_SIZE-1:0]   secondaryAddress,
    output logic                      secondaryReady,
    output logic [8*BYTE_COUNT-1:0]   secondaryDataRead,
    output logic                      secondaryReadValid
);

    localparam int WORD_SIZE     = 8 * BYTE_COUNT;
    localparam int COLUMN_COUNT  = BYTE_COUNT / 4;
    localparam int BANK_BITS     = ADDRESS_SIZE - MACRO_ADDRESS_SIZE;
    localparam int BANK_COUNT    = 1 << BANK_BITS;
    localparam int BANK_SEL_SIZE = (BANK_BITS > 0) ? BANK_BITS : 1;

    state_t                          r_state;
    state_t                          w_nextState;
    logic [MACRO_ADDRESS_SIZE-1:0]   r_clearCount;
    logic                            w_clearing;
    logic                            w_running;

    logic [BANK_SEL_SIZE-1:0]        w_primaryBank;
    logic [BANK_SEL_SIZE-1:0]        w_secondaryBank;
    logic [BANK_SEL_SIZE-1:0]        r_primaryBank1;
    logic [BANK_SEL_SIZE-1:0]        r_primaryBank2;
    logic [BANK_SEL_SIZE-1:0]        r_secondaryBank1;
    logic [BANK_SEL_SIZE-1:0]        r_secondaryBank2;
    logic                            r_primaryPending1;
    logic                            r_primaryPending2;
    logic                            r_secondaryPending1;
    logic                            r_secondaryPending2;

    logic                            w_collision;
    logic                            w_primaryAccept;
    logic                            w_primaryRead;
    logic                            w_primaryWrite;
    logic                            w_secondaryAccept;

    logic                            w_web0;
    logic [BYTE_COUNT-1:0]           w_mask0;
    logic [MACRO_ADDRESS_SIZE-1:0]   w_addr0;
    logic [WORD_SIZE-1:0]            w_din0;
    logic [WORD_SIZE-1:0]            w_primaryDout   [BANK_COUNT];
    logic [WORD_SIZE-1:0]            w_secondaryDout [BANK_COUNT];

    if (BANK_BITS > 0) begin : g_bankSelect
        assign w_primaryBank   = primaryAddress[ADDRESS_SIZE-1:MACRO_ADDRESS_SIZE];
        assign w_secondaryBank = secondaryAddress[ADDRESS_SIZE-1:MACRO_ADDRESS_SIZE];
    end else begin : g_singleBank
        assign w_primaryBank   = '0;
        assign w_secondaryBank = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= CLEAR_ON_RESET ? CLEAR : RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            CLEAR:   if (r_clearCount == MACRO_ADDRESS_SIZE'(MACRO_DEPTH - 1)) w_nextState = RUN;
            RUN:     w_nextState = RUN;
            default: w_nextState = RUN;
        endcase
    end

    // Ready must stay low while reset is held, even when reset lands directly in RUN.
    always_comb begin
        w_clearing = 1'b0;
        w_running  = 1'b0;
        case (r_state)
            CLEAR:   w_clearing = 1'b1;
            RUN:     w_running  = rst;
            default: w_running  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clearCount <= '0;
        end else if (w_clearing) begin
            r_clearCount <= r_clearCount + 1'b1;
        end
    end

    assign w_collision       = primarySelect && primaryWriteEnable && secondarySelect
                               && (primaryAddress == secondaryAddress);
    assign primaryReady      = w_running;
    assign secondaryReady    = w_running && !w_collision;
    assign w_primaryAccept   = primarySelect && w_running;
    assign w_primaryRead     = w_primaryAccept && !primaryWriteEnable;
    assign w_primaryWrite    = w_primaryAccept && primaryWriteEnable;
    assign w_secondaryAccept = secondarySelect && secondaryReady;

    always_comb begin
        w_web0  = !(w_clearing || w_primaryWrite);
        w_mask0 = w_clearing ? '1 : primaryWriteMask;
        w_addr0 = w_clearing ? r_clearCount : primaryAddress[MACRO_ADDRESS_SIZE-1:0];
        w_din0  = w_clearing ? '0 : primaryDataWrite;
    end

    // During clear every row is selected so all banks are zeroed in parallel.
    for (genvar b = 0; b < BANK_COUNT; b++) begin : g_row
        logic w_csb0;
        logic w_csb1;

        assign w_csb0 = !(w_clearing || (w_primaryAccept && (w_primaryBank == BANK_SEL_SIZE'(b))));
        assign w_csb1 = !(w_secondaryAccept && (w_secondaryBank == BANK_SEL_SIZE'(b)));

        sram_bank_row #(
            .COLUMN_COUNT(COLUMN_COUNT)
        ) u_row (
`ifdef USE_POWER_PINS
            .vccd1    (vccd1),
            .vssd1    (vssd1),
`endif
            .clk      (clk),
            .i_csb0   (w_csb0),
            .i_web0   (w_web0),
            .i_wmask0 (w_mask0),
            .i_addr0  (w_addr0),
            .i_din0   (w_din0),
            .o_dout0  (w_primaryDout[b]),
            .i_csb1   (w_csb1),
            .i_addr1  (secondaryAddress[MACRO_ADDRESS_SIZE-1:0]),
            .o_dout1  (w_secondaryDout[b])
        );
    end

    // Bank index travels with the read so the right macro output is picked when it arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_primaryPending1   <= 1'b0;
            r_primaryPending2   <= 1'b0;
            r_primaryBank1      <= '0;
            r_primaryBank2      <= '0;
            r_secondaryPending1 <= 1'b0;
            r_secondaryPending2 <= 1'b0;
            r_secondaryBank1    <= '0;
            r_secondaryBank2    <= '0;
            primaryDataRead     <= '0;
            primaryReadValid    <= 1'b0;
            secondaryDataRead   <= '0;
            secondaryReadValid  <= 1'b0;
        end else begin
            r_primaryPending1   <= w_primaryRead;
            r_primaryBank1      <= w_primaryBank;
            r_primaryPending2   <= r_primaryPending1;
            r_primaryBank2      <= r_primaryBank1;
            r_secondaryPending1 <= w_secondaryAccept;
            r_secondaryBank1    <= w_secondaryBank;
            r_secondaryPending2 <= r_secondaryPending1;
            r_secondaryBank2    <= r_secondaryBank1;
            primaryReadValid    <= r_primaryPending2;
            secondaryReadValid  <= r_secondaryPending2;
            if (r_primaryPending2) begin
                primaryDataRead <= w_primaryDout[r_primaryBank2];
            end
            if (r_secondaryPending2) begin
                secondaryDataRead <= w_secondaryDout[r_secondaryBank2];
            end
        end
    end

endmodule

// File: tb/tb_sram_bank_array.sv
// Self-checking bench: directed vector table, hand sequences and random traffic
// scored against a word-array model of the memory with per-port result queues.
module tb_sram_bank_array;

    localparam int BYTES = 8;
    localparam int ASIZE = 11;
    localparam int DEPTH = 2048;

    logic          clk = 1'b0;
    logic          rst;
    logic          primarySelect;
    logic          primaryWriteEnable;
    logic [7:0]    primaryWriteMask;
    logic [10:0]   primaryAddress;
    logic [63:0]   primaryDataWrite;
    logic          primaryReady;
    logic [63:0]   primaryDataRead;
    logic          primaryReadValid;
    logic          secondarySelect;
    logic [10:0]   secondaryAddress;
    logic          secondaryReady;
    logic [63:0]   secondaryDataRead;
    logic          secondaryReadValid;

    sram_bank_array #(
        .BYTE_COUNT(BYTES),
        .ADDRESS_SIZE(ASIZE),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .primarySelect      (primarySelect),
        .primaryWriteEnable (primaryWriteEnable),
        .primaryWriteMask   (primaryWriteMask),
        .primaryAddress     (primaryAddress),
        .primaryDataWrite   (primaryDataWrite),
        .primaryReady       (primaryReady),
        .primaryDataRead    (primaryDataRead),
        .primaryReadValid   (primaryReadValid),
        .secondarySelect    (secondarySelect),
        .secondaryAddress   (secondaryAddress),
        .secondaryReady     (secondaryReady),
        .secondaryDataRead  (secondaryDataRead),
        .secondaryReadValid (secondaryReadValid)
    );

    always #5 clk = ~clk;

    int edgeCount = 0;
    always @(posedge clk) edgeCount++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          due;
        logic [63:0] data;
    } pend_t;

    typedef struct {
        logic        psel;
        logic        pwe;
        logic [7:0]  pmask;
        logic [10:0] paddr;
        logic [63:0] pdata;
        logic        ssel;
        logic [10:0] saddr;
        logic        expSReady;
    } vec_t;

    logic [63:0] model [DEPTH];
    pend_t       qP[$];
    pend_t       qS[$];
    logic [63:0] lastP;
    logic [63:0] lastS;
    vec_t        vectors [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        qP.delete();
        qS.delete();
        lastP = '0;
        lastS = '0;
    endtask

    task automatic driveIdle();
        primarySelect      = 1'b0;
        primaryWriteEnable = 1'b0;
        primaryWriteMask   = '0;
        primaryAddress     = '0;
        primaryDataWrite   = '0;
        secondarySelect    = 1'b0;
        secondaryAddress   = '0;
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, ".primaryReady"},       primaryReady,       0);
        check({tag, ".secondaryReady"},     secondaryReady,     0);
        check({tag, ".primaryReadValid"},   primaryReadValid,   0);
        check({tag, ".secondaryReadValid"}, secondaryReadValid, 0);
        check({tag, ".primaryDataRead"},    primaryDataRead,    0);
        check({tag, ".secondaryDataRead"},  secondaryDataRead,  0);
    endtask

    // Called just after a negedge while in RUN; the following posedge is the acceptance edge.
    task automatic applyStimulus(input logic psel, input logic pwe, input logic [7:0] pmask,
                                 input logic [10:0] paddr, input logic [63:0] pdata,
                                 input logic ssel, input logic [10:0] saddr);
        logic expS;
        primarySelect      = psel;
        primaryWriteEnable = pwe;
        primaryWriteMask   = pmask;
        primaryAddress     = paddr;
        primaryDataWrite   = pdata;
        secondarySelect    = ssel;
        secondaryAddress   = saddr;
        #1;
        expS = !(psel && pwe && ssel && (paddr == saddr));
        check("primaryReady", primaryReady, 1);
        check("secondaryReady", secondaryReady, expS);
        if (psel && !pwe) qP.push_back('{edgeCount + 3, model[paddr]});
        if (ssel && expS) qS.push_back('{edgeCount + 3, model[saddr]});
        if (psel && pwe) begin
            for (int b = 0; b < BYTES; b++) begin
                if (pmask[b]) model[paddr][8*b +: 8] = pdata[8*b +: 8];
            end
        end
    endtask

    task automatic checkOutput();
        logic expV;
        expV = (qP.size() > 0) && (qP[0].due == edgeCount);
        check("primaryReadValid", primaryReadValid, expV);
        if (expV) begin
            lastP = qP[0].data;
            void'(qP.pop_front());
        end
        check("primaryDataRead", primaryDataRead, lastP);
        expV = (qS.size() > 0) && (qS[0].due == edgeCount);
        check("secondaryReadValid", secondaryReadValid, expV);
        if (expV) begin
            lastS = qS[0].data;
            void'(qS.pop_front());
        end
        check("secondaryDataRead", secondaryDataRead, lastS);
    endtask

    task automatic runCycle(input logic psel, input logic pwe, input logic [7:0] pmask,
                            input logic [10:0] paddr, input logic [63:0] pdata,
                            input logic ssel, input logic [10:0] saddr);
        applyStimulus(psel, pwe, pmask, paddr, pdata, ssel, saddr);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idleCycle();
        runCycle(0, 0, 8'h00, 11'd0, 64'd0, 0, 11'd0);
    endtask

    // Entered right after rst rises; returns just after the first negedge with ready high.
    task automatic waitClear(input string name);
        int cnt;
        bit secSeen;
        cnt     = 0;
        secSeen = 0;
        while (primaryReady !== 1'b1 && cnt < 2000) begin
            if (secondaryReady) secSeen = 1;
            cnt++;
            @(negedge clk);
            #1;
        end
        check(name, cnt, 512);
        check({name, ".secondaryReadyLow"}, secSeen, 0);
    endtask

    function automatic logic [10:0] pickAddress();
        case ($urandom_range(0, 3))
            0:       return 11'd3;
            1:       return 11'd7;
            2:       return 11'h603;
            default: return 11'($urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    initial begin
        int pCnt;
        int sCnt;
        int lowCnt;
        logic [10:0] pa;
        logic [10:0] sa;

        vectors[0]  = '{1, 1, 8'hFF, 11'd5,     64'h1122334455667788, 0, 11'd0,     1};
        vectors[1]  = '{1, 1, 8'h0F, 11'd5,     64'hFFFFFFFFFFFFFFFF, 0, 11'd0,     1};
        vectors[2]  = '{1, 0, 8'h00, 11'd5,     64'd0,                1, 11'd5,     1};
        vectors[3]  = '{1, 1, 8'hFF, 11'd7,     64'h00000000DEADBEEF, 1, 11'd7,     0};
        vectors[4]  = '{0, 0, 8'h00, 11'd0,     64'd0,                1, 11'd7,     1};
        vectors[5]  = '{1, 1, 8'hFF, 11'd9,     64'h00000000A5A5A5A5, 0, 11'd0,     1};
        vectors[6]  = '{1, 1, 8'h00, 11'd9,     64'hFFFFFFFFFFFFFFFF, 0, 11'd0,     1};
        vectors[7]  = '{1, 0, 8'h00, 11'd9,     64'd0,                1, 11'h609,   1};
        vectors[8]  = '{1, 1, 8'hFF, 11'd3,     64'h0303030303030303, 1, 11'h603,   1};
        vectors[9]  = '{1, 1, 8'hFF, 11'h603,   64'h0606060606060606, 1, 11'd3,     1};
        vectors[10] = '{1, 0, 8'h00, 11'h603,   64'd0,                1, 11'h7FF,   1};

        rst = 1'b0;
        driveIdle();
        resetModel();
        repeat (3) @(negedge clk);
        #1;
        checkResetOutputs("reset");

        @(negedge clk);
        rst = 1'b1;
        #1;
        waitClear("clearCycles");

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vectors[i].psel, vectors[i].pwe, vectors[i].pmask, vectors[i].paddr,
                          vectors[i].pdata, vectors[i].ssel, vectors[i].saddr);
            check("tableSecondaryReady", secondaryReady, vectors[i].expSReady);
            @(negedge clk);
            checkOutput();
        end
        repeat (3) idleCycle();

        runCycle(1, 0, 8'h00, 11'd5, 64'd0, 0, 11'd0);
        idleCycle();
        idleCycle();
        check("maskedReadValid", primaryReadValid, 1);
        check("maskedReadData", primaryDataRead, 64'h11223344FFFFFFFF);

        runCycle(1, 0, 8'h00, 11'd9, 64'd0, 0, 11'd0);
        idleCycle();
        idleCycle();
        check("zeroMaskReadData", primaryDataRead, 64'h00000000A5A5A5A5);

        runCycle(1, 1, 8'hFF, 11'd7, 64'h000000000BADF00D, 0, 11'd0);
        applyStimulus(1, 1, 8'hFF, 11'd7, 64'h00000000DEADBEEF, 1, 11'd7);
        check("collisionStall", secondaryReady, 0);
        @(negedge clk);
        checkOutput();
        applyStimulus(0, 0, 8'h00, 11'd0, 64'd0, 1, 11'd7);
        check("collisionRetryReady", secondaryReady, 1);
        @(negedge clk);
        checkOutput();
        idleCycle();
        idleCycle();
        check("collisionReadValid", secondaryReadValid, 1);
        check("collisionReadData", secondaryDataRead, 64'h00000000DEADBEEF);

        pCnt = 0;
        sCnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) runCycle(1, 0, 8'h00, 11'd3, 64'd0, 1, 11'h603);
            else       idleCycle();
            if (primaryReadValid)   pCnt++;
            if (secondaryReadValid) sCnt++;
        end
        check("parallelPrimaryCount", pCnt, 8);
        check("parallelSecondaryCount", sCnt, 8);

        for (int i = 0; i < 400; i++) begin
            pa = pickAddress();
            sa = ($urandom_range(0, 1) == 0) ? pa : pickAddress();
            runCycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 255)), pa, {$urandom, $urandom},
                     1'($urandom_range(0, 9) < 7), sa);
        end
        driveIdle();
        repeat (4) idleCycle();
        check("drainPrimary", qP.size(), 0);
        check("drainSecondary", qS.size(), 0);

        #2;
        rst = 1'b0;
        #1;
        checkResetOutputs("resetAfterTraffic");
        resetModel();
        @(negedge clk);
        rst = 1'b1;
        lowCnt = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (!primaryReady && !secondaryReady) lowCnt++;
            @(negedge clk);
        end
        check("readyLowFirst200", lowCnt, 200);
        rst = 1'b0;
        #1;
        checkResetOutputs("resetMidClear");
        @(negedge clk);
        rst = 1'b1;
        #1;
        waitClear("clearCyclesAfterRestart");

        runCycle(1, 0, 8'h00, 11'd0,    64'd0, 1, 11'd511);
        runCycle(1, 0, 8'h00, 11'd512,  64'd0, 1, 11'd1023);
        runCycle(1, 0, 8'h00, 11'd5,    64'd0, 1, 11'd7);
        runCycle(1, 0, 8'h00, 11'h603,  64'd0, 1, 11'd2047);
        repeat (3) idleCycle();
        check("drainFinal", qP.size() + qS.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
